decoder_for_out_seq: RTL and testbench
======================================

Name: decoder_for_out_seq

Overview:
- Registered, mode-programmable successor to the one-hot output decoder.
- Holds an index `idx` and drives one-hot `out[idx-1]`; `idx` 0 or above OUT_SIZE drives all-zero.
- `idx` is loaded from `in`, then either held, auto-swept with a programmable period, or shown as a timed pulse.
- Sits between top-level control logic and the output pin / LED bank.

Parameters:
- IN_SIZE, 6, width of `in` and `idx`.
- OUT_SIZE, 34, number of one-hot outputs; must be ≤ 2^IN_SIZE-1.
- DIV_WIDTH, 4, width of the period / pulse-length operand `div`.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- en  input  1  advance enable; low freezes all state, counters and outputs.
- load  input  1  load strobe; sampled only when en=1.
- mode  input  2  00 DIRECT, 01 SWEEP, 10 PULSE, 11 reserved (treated as DIRECT).
- in  input  IN_SIZE  index to load.
- div  input  DIV_WIDTH  SWEEP step period / PULSE length = div+1 enabled cycles; sampled at load.
- out  output  OUT_SIZE  registered one-hot, or zero.
- idx  output  IN_SIZE  current index register.
- busy  output  1  high in S_SWEEP or S_PULSE.
- wrap  output  1  one-cycle pulse on SWEEP wrap from OUT_SIZE to 1.

Behaviour:
- Reset (n_rst low, async): idx=0, out=0, busy=0, wrap=0, cnt=0, period=0, state=S_IDLE.
- Decode rule: out = (1≤idx≤OUT_SIZE) ? 1<<(idx-1) : 0.
  - `out` is registered and updated on the same edge as `idx`.
  - `out` always matches the decode of the current `idx`.
- Load latency: 1 cycle. `in` sampled at edge N appears on idx/out after edge N.
- en=0: load ignored; idx, out, cnt and state hold; wrap=0.
- FSM states: S_IDLE, S_SWEEP, S_PULSE. `load` (with en=1) restarts from any state:
  - DIRECT/11: idx<=in, period<=div, cnt<=0, state<=S_IDLE.
  - SWEEP: idx<=(in==0 || in>OUT_SIZE) ? 1 : in; period<=div; cnt<=0; state<=S_SWEEP.
  - PULSE: idx<=in, period<=div, cnt<=0, state<=S_PULSE.
  - PULSE with in==0 or in>OUT_SIZE: state<=S_IDLE.
- S_IDLE: idx held indefinitely.
- S_SWEEP, each en=1 cycle without load:
  - cnt==period: cnt<=0 and idx steps (idx==OUT_SIZE ? 1 : idx+1).
  - Stepping OUT_SIZE→1 asserts wrap for exactly that cycle.
  - Otherwise cnt<=cnt+1.
  - Each index is displayed for period+1 enabled cycles.
- S_PULSE, each en=1 cycle without load:
  - cnt==period: idx<=0 (out=0), state<=S_IDLE.
  - Otherwise cnt<=cnt+1.
  - Pulse width is exactly period+1 enabled cycles.
- `mode` and `div` changes without load have no effect on a running state.
- `load` on the same cycle as a sweep step or pulse end: load wins.
- Arithmetic:
  - cnt and period are DIV_WIDTH bits; no overflow is possible since cnt ≤ period.
  - idx increment never exceeds OUT_SIZE.
- busy = (state != S_IDLE), registered.
- Async reset mid-sweep or mid-pulse clears everything immediately, independent of clk.

Test Plan:
- Reset then DIRECT: load in=1..34, one cycle each, en=1.
  - One cycle after each load, out==34'b1<<(in-1) and idx==in.
  - Loading in=0 and in=40 gives out==0.
- SWEEP with div=0, load in=33: out shows bit 32, bit 33, then bit 0 on successive cycles.
  - wrap=1 only in the cycle idx becomes 1; busy=1 throughout.
  - Loading in=0 starts at idx=1.
- SWEEP with div=3, load in=5: idx stays 5 for 4 cycles, then 6.
  - Dropping en for 7 cycles mid-period freezes idx/cnt.
  - Resuming en completes the remaining count exactly.
- PULSE with div=2, load in=10: out==1<<9 for exactly 3 cycles, then out==0, idx==0, busy==0.
  - Load in=40 in PULSE mode: out stays 0, busy stays 0.
- Retrigger and priority:
  - PULSE in=3 div=5; at cycle 2, load DIRECT in=7 → next cycle out==1<<6, busy=0.
  - Load asserted with en=0 is ignored.
  - Changing mode without load leaves the running sweep unaffected.
- Async reset: assert n_rst low mid-SWEEP, away from a clk edge.
  - out, idx, busy and wrap go to 0 immediately.
  - After release, state stays S_IDLE until the next load.

Source files
------------

// File: rtl/decoder_for_out_seq.sv
// Registered one-hot output decoder with a programmable index sequencer:
// the index is loaded directly, auto-swept with a period, or shown as a timed pulse.
module decoder_for_out_seq #(
  parameter int IN_SIZE   = 6,
  parameter int OUT_SIZE  = 34,
  parameter int DIV_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [1:0]           mode,
  input  logic [IN_SIZE-1:0]   in,
  input  logic [DIV_WIDTH-1:0] div,
  output logic [OUT_SIZE-1:0]  out,
  output logic [IN_SIZE-1:0]   idx,
  output logic                 busy,
  output logic                 wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  localparam logic [IN_SIZE-1:0]   IDX_ZERO = {IN_SIZE{1'b0}};
  localparam logic [IN_SIZE-1:0]   IDX_ONE  = {{(IN_SIZE-1){1'b0}}, 1'b1};
  localparam logic [IN_SIZE-1:0]   IDX_MAX  = IN_SIZE'(OUT_SIZE);
  localparam logic [DIV_WIDTH-1:0] CNT_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OUT_SIZE-1:0]  OUT_ONE  = {{(OUT_SIZE-1){1'b0}}, 1'b1};
  localparam logic [OUT_SIZE-1:0]  OUT_ZERO = {OUT_SIZE{1'b0}};

  function automatic logic idx_valid(input logic [IN_SIZE-1:0] v);
    return (v != IDX_ZERO) && (v <= IDX_MAX);
  endfunction

  function automatic logic [OUT_SIZE-1:0] decode(input logic [IN_SIZE-1:0] v);
    logic [OUT_SIZE-1:0] res;
    if (idx_valid(v)) begin
      res = OUT_ONE << (v - IDX_ONE);
    end else begin
      res = OUT_ZERO;
    end
    return res;
  endfunction

  state_t               state_q, state_d;
  logic [IN_SIZE-1:0]   idx_q, idx_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] period_q, period_d;
  logic [OUT_SIZE-1:0]  out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 wrap_q, wrap_d;

  // Next-state logic: a load restarts the sequencer from any state and wins over a step.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    if (en) begin
      if (load) begin
        period_d = div;
        cnt_d    = CNT_ZERO;
        case (mode)
          2'b01: begin
            idx_d   = idx_valid(in) ? in : IDX_ONE;
            state_d = S_SWEEP;
          end
          2'b10: begin
            idx_d   = in;
            state_d = idx_valid(in) ? S_PULSE : S_IDLE;
          end
          default: begin
            idx_d   = in;
            state_d = S_IDLE;
          end
        endcase
      end else begin
        case (state_q)
          S_SWEEP: begin
            if (cnt_q == period_q) begin
              cnt_d = CNT_ZERO;
              if (idx_q == IDX_MAX) begin
                idx_d  = IDX_ONE;
                wrap_d = 1'b1;
              end else begin
                idx_d = idx_q + IDX_ONE;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          S_PULSE: begin
            if (cnt_q == period_q) begin
              idx_d   = IDX_ZERO;
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
    out_d  = decode(idx_d);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= IDX_ZERO;
      cnt_q    <= CNT_ZERO;
      period_q <= CNT_ZERO;
      out_q    <= OUT_ZERO;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      wrap_q   <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_for_out_seq.sv
// Randomized and directed bench for decoder_for_out_seq against a remaining-cycles
// reference model of the sequencer.
module tb_decoder_for_out_seq;

  logic        clk;
  logic        n_rst;
  logic        en;
  logic        load;
  logic [1:0]  mode;
  logic [5:0]  in;
  logic [3:0]  div;
  logic [33:0] out;
  logic [5:0]  idx;
  logic        busy;
  logic        wrap;

  int n_checks;
  int n_errors;

  // model: 0 idle, 1 sweep, 2 pulse; remain = enabled cycles left on the current display
  int m_idx;
  int m_st;
  int m_remain;
  int m_period;
  int m_wrap;

  decoder_for_out_seq #(.IN_SIZE(6), .OUT_SIZE(34), .DIV_WIDTH(4)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .en   (en),
    .load (load),
    .mode (mode),
    .in   (in),
    .div  (div),
    .out  (out),
    .idx  (idx),
    .busy (busy),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [33:0] exp_out(input int i);
    logic [33:0] e;
    e = 34'd0;
    if (i >= 1 && i <= 34) e[i-1] = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_st = 0; m_remain = 0; m_period = 0; m_wrap = 0;
  endtask

  task automatic model_edge();
    m_wrap = 0;
    if (en) begin
      if (load) begin
        m_period = int'(div);
        m_remain = int'(div) + 1;
        if (mode == 2'b01) begin
          m_idx = (in == 6'd0 || in > 6'd34) ? 1 : int'(in);
          m_st  = 1;
        end else if (mode == 2'b10) begin
          m_idx = int'(in);
          m_st  = (in == 6'd0 || in > 6'd34) ? 0 : 2;
        end else begin
          m_idx = int'(in);
          m_st  = 0;
        end
      end else if (m_st == 1) begin
        m_remain = m_remain - 1;
        if (m_remain == 0) begin
          if (m_idx == 34) begin
            m_idx  = 1;
            m_wrap = 1;
          end else begin
            m_idx = m_idx + 1;
          end
          m_remain = m_period + 1;
        end
      end else if (m_st == 2) begin
        m_remain = m_remain - 1;
        if (m_remain == 0) begin
          m_idx = 0;
          m_st  = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".out"},  64'(out),  64'(exp_out(m_idx)));
    check_val({tag, ".idx"},  64'(idx),  64'(m_idx));
    check_val({tag, ".busy"}, 64'(busy), 64'(m_st != 0));
    check_val({tag, ".wrap"}, 64'(wrap), 64'(m_wrap));
  endtask

  task automatic cyc(input string tag, input logic e, input logic l, input logic [1:0] m,
                     input logic [5:0] i, input logic [3:0] d);
    en = e; load = l; mode = m; in = i; div = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_rst = 1'b0;
    en = 1'b0; load = 1'b0; mode = 2'b00; in = 6'd0; div = 4'd0;
    model_reset();
    #12;
    check_all("reset");
    n_rst = 1'b1;

    for (int i = 1; i <= 34; i++) cyc("direct", 1'b1, 1'b1, 2'b00, 6'(i), 4'd0);
    cyc("direct0", 1'b1, 1'b1, 2'b00, 6'd0, 4'd0);
    cyc("direct40", 1'b1, 1'b1, 2'b00, 6'd40, 4'd0);
    cyc("direct40h", 1'b1, 1'b0, 2'b00, 6'd0, 4'd0);

    cyc("sw0_load", 1'b1, 1'b1, 2'b01, 6'd33, 4'd0);
    check_val("sw0_first", 64'(out), 64'(34'h1_0000_0000));
    cyc("sw0_a", 1'b1, 1'b0, 2'b01, 6'd0, 4'd0);
    check_val("sw0_top", 64'(out), 64'(34'h2_0000_0000));
    cyc("sw0_b", 1'b1, 1'b0, 2'b01, 6'd0, 4'd0);
    check_val("sw0_wrap", 64'({wrap, out}), 64'({1'b1, 34'h1}));
    cyc("sw0_c", 1'b1, 1'b0, 2'b01, 6'd0, 4'd0);
    cyc("sw0_in0", 1'b1, 1'b1, 2'b01, 6'd0, 4'd0);
    check_val("sw0_start1", 64'(idx), 64'd1);

    cyc("sw3_load", 1'b1, 1'b1, 2'b01, 6'd5, 4'd3);
    cyc("sw3_a", 1'b1, 1'b0, 2'b00, 6'd9, 4'd9);
    for (int k = 0; k < 7; k++) cyc("sw3_frz", 1'b0, 1'b1, 2'b10, 6'd9, 4'd9);
    for (int k = 0; k < 3; k++) cyc("sw3_b", 1'b1, 1'b0, 2'(k), 6'd0, 4'd0);
    check_val("sw3_step6", 64'(idx), 64'd6);
    for (int k = 0; k < 3; k++) cyc("sw3_c", 1'b1, 1'b0, 2'b11, 6'd0, 4'd0);

    cyc("pl_load", 1'b1, 1'b1, 2'b10, 6'd10, 4'd2);
    for (int k = 0; k < 4; k++) cyc("pl_run", 1'b1, 1'b0, 2'b00, 6'd0, 4'd0);
    check_val("pl_end", 64'({busy, idx}), 64'd0);
    cyc("pl40", 1'b1, 1'b1, 2'b10, 6'd40, 4'd2);
    cyc("pl40h", 1'b1, 1'b0, 2'b10, 6'd0, 4'd2);

    cyc("rt_load", 1'b1, 1'b1, 2'b10, 6'd3, 4'd5);
    cyc("rt_a", 1'b1, 1'b0, 2'b00, 6'd0, 4'd0);
    cyc("rt_direct", 1'b1, 1'b1, 2'b00, 6'd7, 4'd0);
    check_val("rt_out", 64'({busy, out}), 64'({1'b0, 34'h40}));
    cyc("rt_en0", 1'b0, 1'b1, 2'b01, 6'd20, 4'd0);

    cyc("ar_load", 1'b1, 1'b1, 2'b01, 6'd12, 4'd1);
    cyc("ar_a", 1'b1, 1'b0, 2'b01, 6'd0, 4'd0);
    cyc("ar_b", 1'b1, 1'b0, 2'b01, 6'd0, 4'd0);
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_all("ar_async");
    #3;
    n_rst = 1'b1;
    for (int k = 0; k < 4; k++) cyc("ar_idle", 1'b1, 1'b0, 2'b01, 6'd9, 4'd0);

    for (int k = 0; k < 3000; k++) begin
      cyc("rand",
          ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
          ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(28, 34)),
          4'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
